// File: rtl/scan_decoder_pkg.sv
// Shared types, mode constants and the one-hot helper for the scan_decoder slice.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper accepts; callers cast the result down to their own width.
    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot_n(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/scan_decoder_prescaler.sv
// Dwell prescaler for scan_decoder: counts while run is high and pulses step
// once the count reaches div.
module scan_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // ">=" lets a lowered div take effect on the very next clock.
    always_comb begin
        step  = run && (cnt_q >= div);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = step ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N active-low decoder with auto-scan; defining
// SCAN_DECODER_BLANK_EN inserts one all-ones blank clock before each scan step.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DIV_W-1:0]      div,
    output logic [2**SEL_W-1:0]   yl,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned OUT_W = 2**SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   yl_q, yl_d;
    logic               wrap_q, wrap_d;
    logic               ps_clr, ps_run, step;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .run  (ps_run),
        .div  (div),
        .step (step)
    );

    // Actions follow the state being entered on this edge, so DIRECT has one clock of latency.
    always_comb begin
        if (!en) begin
            state_d = ST_OFF;
        end else if (mode == MODE_SCAN) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end

        ps_clr = (state_d == ST_DIRECT) || (state_d == ST_SCAN && state_q != ST_SCAN);
        ps_run = (state_d == ST_SCAN) && (state_q == ST_SCAN);

        idx_d  = idx_q;
        wrap_d = 1'b0;
        yl_d   = '1;

        unique case (state_d)
            ST_DIRECT: idx_d = sel;
            ST_SCAN: begin
                if (step) begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == '1);
                end
            end
            default: ;
        endcase

        if (state_d != ST_OFF) begin
            yl_d = ~OUT_W'(onehot_n(MAX_SEL_W'(idx_d)));
        end
`ifdef SCAN_DECODER_BLANK_EN
        if (step) begin
            yl_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            yl_q    <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            yl_q    <= yl_d;
            wrap_q  <= wrap_d;
        end
    end

    assign yl   = yl_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=3, DIV_W=16); blank-cycle expectations
// switch with SCAN_DECODER_BLANK_EN.
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [15:0] div;
    logic [7:0]  yl;
    logic [2:0]  idx;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    logic [7:0] dec_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    scan_decoder #(
        .SEL_W (3),
        .DIV_W (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .sel  (sel),
        .div  (div),
        .yl   (yl),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         e_idx;
        logic [7:0] e_yl;

        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd5; div = 16'd0;
        tick();
        tick();
        chk("rst_yl", 32'(yl), 32'hFF);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);

        rst = 1'b0;
        tick();
        chk("post_rst_idx", 32'(idx), 32'd5);
        chk("post_rst_yl", 32'(yl), 32'hDF);

        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
            chk("direct_idx", 32'(idx), 32'(i));
            chk("direct_yl", 32'(yl), 32'(dec_tbl[i]));
        end

        en = 1'b0;
        tick();
        chk("off_yl", 32'(yl), 32'hFF);
        chk("off_idx_hold", 32'(idx), 32'd7);
        chk("off_wrap", 32'(wrap), 32'd0);

        // Scan with div=2 starting from idx 0.
        en = 1'b1; mode = 1'b0; sel = 3'd0;
        tick();
        chk("pre_scan_idx", 32'(idx), 32'd0);
        mode = 1'b1; div = 16'd2;
        tick();
        chk("scan_entry_idx", 32'(idx), 32'd0);
        chk("scan_entry_yl", 32'(yl), 32'hFE);
        for (int k = 1; k <= 26; k++) begin
            tick();
            e_idx = (k / 3) % 8;
            e_yl  = dec_tbl[e_idx];
`ifdef SCAN_DECODER_BLANK_EN
            if (k % 3 == 0) e_yl = 8'hFF;
`endif
            chk("scan2_idx", 32'(idx), 32'(e_idx));
            chk("scan2_yl", 32'(yl), 32'(e_yl));
            chk("scan2_wrap", 32'(wrap), (k == 24) ? 32'd1 : 32'd0);
        end

        // div=0: advance every clock (prescaler currently at 2).
        div = 16'd0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("scan0_idx", 32'(idx), 32'(k));
            chk("scan0_wrap", 32'(wrap), 32'd0);
        end

        // div=9, let prescaler reach 6, then lower div to 3.
        div = 16'd9;
        repeat (6) tick();
        chk("div9_idx", 32'(idx), 32'd4);
        div = 16'd3;
        tick();
        chk("div_lower_idx", 32'(idx), 32'd5);
        repeat (3) tick();
        chk("div3_hold_idx", 32'(idx), 32'd5);
        tick();
        chk("div3_step_idx", 32'(idx), 32'd6);

        // Freeze mid-scan at idx 4, prescaler 1, then re-enter scan.
        mode = 1'b0; sel = 3'd4;
        tick();
        mode = 1'b1;
        tick();
        tick();
        chk("frz_pre_idx", 32'(idx), 32'd4);
        en = 1'b0;
        tick();
        chk("frz_off_yl", 32'(yl), 32'hFF);
        tick();
        chk("frz_off_idx", 32'(idx), 32'd4);
        en = 1'b1;
        tick();
        chk("reentry_idx", 32'(idx), 32'd4);
        chk("reentry_yl", 32'(yl), 32'hEF);
        repeat (3) tick();
        chk("reentry_hold_idx", 32'(idx), 32'd4);
        tick();
        chk("reentry_step_idx", 32'(idx), 32'd5);
`ifdef SCAN_DECODER_BLANK_EN
        chk("blank_yl", 32'(yl), 32'hFF);
`else
        chk("step_yl", 32'(yl), 32'hDF);
`endif
        tick();
        chk("dwell_yl", 32'(yl), 32'hDF);

        // Scan -> direct takes sel on the first direct cycle.
        mode = 1'b0; sel = 3'd2;
        tick();
        chk("to_direct_idx", 32'(idx), 32'd2);
        chk("to_direct_yl", 32'(yl), 32'hFB);
        chk("to_direct_wrap", 32'(wrap), 32'd0);

        // Asynchronous reset in the middle of a scan.
        mode = 1'b1; div = 16'd0;
        tick();
        tick();
        chk("pre_rst_idx", 32'(idx), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_idx", 32'(idx), 32'd0);
        chk("async_rst_yl", 32'(yl), 32'hFF);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        tick();
        chk("held_rst_idx", 32'(idx), 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
